// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch queue.
//   fetch_state_t : request tracker state (IDLE / WAIT / DISCARD)
//   fetch_entry_t : one buffered instruction {pc, instr, fault}
//   NOP_INSTR     : instruction substituted for a faulting fetch
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // IDLE    : no read outstanding
    // WAIT    : one read outstanding, its data will be buffered
    // DISCARD : one read outstanding whose data must be thrown away
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
        logic                  fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the PC-side, instruction-memory and decode-side signals of the
// fetch queue.
//   master : the fetch queue itself (drives PCStall, IMemReq/IMemAddr,
//            Instr/InstrPC/InstrValid)
//   slave  : the surrounding pipeline and memory
// Optional: FETCH_MISALIGN_CHECK_EN adds InstrFault (per-entry fault flag).
// -----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    // program_counter side
    logic [XLEN-1:0] PC;
    logic            FetchEn;
    logic            Redirect;
    logic            PCStall;
    // instruction memory side
    logic            IMemReq;
    logic [XLEN-1:0] IMemAddr;
    logic [XLEN-1:0] IMemRdata;
    logic            IMemValid;
    // decode side
    logic [XLEN-1:0] Instr;
    logic [XLEN-1:0] InstrPC;
    logic            InstrValid;
    logic            DecodeReady;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            InstrFault;

    modport master (
        input  PC, FetchEn, Redirect, IMemRdata, IMemValid, DecodeReady,
        output PCStall, IMemReq, IMemAddr, Instr, InstrPC, InstrValid, InstrFault
    );

    modport slave (
        output PC, FetchEn, Redirect, IMemRdata, IMemValid, DecodeReady,
        input  PCStall, IMemReq, IMemAddr, Instr, InstrPC, InstrValid, InstrFault
    );
`else
    modport master (
        input  PC, FetchEn, Redirect, IMemRdata, IMemValid, DecodeReady,
        output PCStall, IMemReq, IMemAddr, Instr, InstrPC, InstrValid
    );

    modport slave (
        output PC, FetchEn, Redirect, IMemRdata, IMemValid, DecodeReady,
        input  PCStall, IMemReq, IMemAddr, Instr, InstrPC, InstrValid
    );
`endif
endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small register-based FIFO of fetch_entry_t for the fetch queue.
//   clk, rst_n   : clock, async active-low reset
//   push_i       : write push_data_i at the tail (caller guarantees not full)
//   push_data_i  : entry to write
//   pop_i        : drop the head entry (ignored when empty)
//   flush_i      : empty the FIFO and zero both pointers; beats push/pop
//   count_o      : number of valid entries
//   head_o       : head entry (registered storage, stale when count_o == 0)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  fetch_entry_t                 push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output fetch_entry_t                 head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && (count_q != '0) && !flush_i;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: the storage is reset because the head entry drives the
            // Instr/InstrPC outputs directly and must read as zero out of reset;
            // with only a handful of entries this costs nothing meaningful.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch stage behind program_counter. Issues one word read per
// accepted PC, keeps at most one read outstanding, and buffers returned
// instructions with their PCs for decode. A redirect squashes everything
// buffered and turns an outstanding read into one whose data is dropped.
//   CLK    : system clock, rising edge
//   Reset  : asynchronous active-low reset
//   bus    : fetch_queue_if.master
//            in : PC, FetchEn, Redirect, IMemRdata, IMemValid, DecodeReady
//            out: PCStall, IMemReq, IMemAddr, Instr, InstrPC, InstrValid
// Optional: FETCH_MISALIGN_CHECK_EN -- a PC with PC[1:0]!=0 is not sent to
// memory; a NOP entry flagged on InstrFault is buffered the next cycle.
// Without it PC[1:0] is ignored for the memory address.
// XLEN must equal fetch_pkg::FETCH_XLEN (the buffered entry width).
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = FETCH_XLEN
) (
    input  logic          CLK,
    input  logic          Reset,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic [OW-1:0]   occ_after;
    logic            resp_push;
    logic            fault_push;
    logic            push;
    logic            pop;
    logic            can_start;
    logic            issue;
    logic            misaligned;
    logic            mem_req;

    // Data returned for a live request is buffered unless a redirect squashes it.
    assign resp_push = (state_q == WAIT) && bus.IMemValid && !bus.Redirect;
    assign push      = resp_push || fault_push;
    assign pop       = (count != '0) && bus.DecodeReady && !bus.Redirect;

    // Entries held after this edge; a new request needs one free slot beyond
    // these so its data can always be accepted without checking for full.
    assign occ_after = OW'(count) + OW'(push) - OW'(pop);

    assign can_start = (state_q == IDLE) || ((state_q == WAIT) && bus.IMemValid);

    // Reset is folded in so PCStall stays high while reset is asserted.
    assign issue   = Reset && bus.FetchEn && !bus.Redirect && can_start
                     && (occ_after < OW'(DEPTH));
    assign mem_req = issue && !misaligned;

    assign bus.PCStall  = !issue;
    assign bus.IMemReq  = mem_req;
    assign bus.IMemAddr = mem_req ? {bus.PC[XLEN-1:2], 2'b00} : '0;

`ifdef FETCH_MISALIGN_CHECK_EN
    // Set for one cycle after a misaligned PC is accepted; that cycle pushes
    // the NOP entry using the captured request PC.
    logic fault_pend_q;

    assign misaligned = bus.PC[1:0] != 2'b00;
    assign fault_push = fault_pend_q && !bus.Redirect;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            fault_pend_q <= 1'b0;
        end else begin
            fault_pend_q <= issue && misaligned;
        end
    end

    assign bus.InstrFault = head.fault;
`else
    logic unused_fault;

    assign misaligned   = 1'b0;
    assign fault_push   = 1'b0;
    assign unused_fault = head.fault;
`endif

    always_comb begin
        push_data.pc    = req_pc_q;
        push_data.instr = fault_push ? NOP_INSTR : bus.IMemRdata;
        push_data.fault = fault_push;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;

        unique case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.Redirect) begin
                    // A response arriving with the redirect is simply dropped;
                    // otherwise it is still in flight and must be swallowed.
                    state_d = bus.IMemValid ? IDLE : DISCARD;
                end else if (bus.IMemValid) begin
                    state_d = mem_req ? WAIT : IDLE;
                end
            end
            DISCARD: begin
                if (bus.IMemValid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            req_pc_d = bus.PC;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst_n       (Reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (bus.Redirect),
        .count_o     (count),
        .head_o      (head)
    );

    assign bus.InstrValid = count != '0;
    assign bus.Instr      = head.instr;
    assign bus.InstrPC    = head.pc;

endmodule
